acc_cpu_p: RTL and testbench
============================

ACC_CPU_P -- requirements
Module: acc_cpu_p

Interface
REQ-001 Parameter DATA_W, default 16, accumulator/instruction/memory data width; SHALL satisfy DATA_W >= ADDR_W+4.
REQ-002 Parameter ADDR_W, default 12, PC/MA/memory address width.
REQ-003 Parameter STA_CLEAR, default 1, 1 = STA clears AC after the store, 0 = AC preserved.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mem_addr  out  ADDR_W  memory address, combinational from state: PC in FETCH, MA otherwise.
REQ-007 mem_rdata  in  DATA_W  synchronous-read RAM data, valid the cycle after mem_addr is presented.
REQ-008 mem_wdata  out  DATA_W  store data, equals AC.
REQ-009 mem_we  out  1  write strobe, high only in STORE and only when rst=0.
REQ-010 ac  out  DATA_W  accumulator.
REQ-011 carry  out  1  carry flag.
REQ-012 pc  out  ADDR_W  program counter.
REQ-013 halted  out  1  high while in HALT.
REQ-014 retire  out  1  one-cycle pulse in the final cycle of each instruction (next state FETCH).

Function
REQ-015 Instruction: opcode = IR[DATA_W-1:DATA_W-3], AM (indirect) = IR[DATA_W-4], operand address = IR[ADDR_W-1:0]; intervening bits ignored.
REQ-016 Opcodes: 000 NOT, 001 ADC, 010 JPA, 011 INC, 100 STA, 101 LDA, 110 AND, 111 HLT.
REQ-017 States: FETCH, LOADIR, DECODE, IND0, IND1, OPER0, OPER1, STORE, HALT.
REQ-018 FETCH: mem_addr=PC -> LOADIR.
REQ-019 LOADIR: IR<=mem_rdata; MA<=mem_rdata[ADDR_W-1:0]; PC<=PC+1 modulo 2^ADDR_W -> DECODE.
REQ-020 DECODE NOT: AC<=~AC, carry unchanged -> FETCH.
REQ-021 DECODE INC: {carry,AC}<=AC+1 -> FETCH.
REQ-022 DECODE HLT -> HALT; HALT is absorbing until rst; no register or memory changes in HALT.
REQ-023 DECODE JPA: AC==0 -> FETCH, no change; AC!=0 and AM=0 -> PC<=MA, FETCH; AC!=0 and AM=1 -> IND0.
REQ-024 DECODE ADC/LDA/AND/STA: AM=1 -> IND0; AM=0 -> STORE for STA, OPER0 otherwise.
REQ-025 IND0: mem_addr=MA -> IND1.
REQ-026 IND1: pointer p=mem_rdata[ADDR_W-1:0]; JPA -> PC<=p, FETCH; STA -> MA<=p, STORE; others -> MA<=p, OPER0.
REQ-027 OPER0: mem_addr=MA -> OPER1.
REQ-028 OPER1: ADC {carry,AC}<=AC+mem_rdata+carry (DATA_W+1-bit sum); LDA AC<=mem_rdata; AND AC<=AC&mem_rdata; carry unchanged for LDA/AND -> FETCH.
REQ-029 STORE: mem_addr=MA, mem_wdata=AC, mem_we=1; AC<=0 if STA_CLEAR=1 -> FETCH.
REQ-030 Latency (cycles incl. FETCH): NOT/INC/HLT 3; JPA not taken 3, direct 3, indirect 5; STA direct 4, indirect 6; ADC/LDA/AND direct 5, indirect 7.
REQ-031 PC wraps 2^ADDR_W-1 -> 0 with no flag; address arithmetic never wider than ADDR_W.
REQ-032 retire not asserted in HALT; asserted in DECODE for HLT.

Reset
REQ-033 rst=1 at a clock edge SHALL force state FETCH; PC, MA, IR, AC, carry = 0; halted=0.
REQ-034 While rst=1: mem_we=0, retire=0, regardless of state, including reset asserted mid-STORE or mid-indirect.
REQ-035 Reset from HALT SHALL resume fetch at address 0 on the first cycle after rst falls.

Verification (DATA_W=16, ADDR_W=12, STA_CLEAR=1)
REQ-036 Reset; mem[0]=0x6000 (INC) -> after 3 cycles ac=0x0001, pc=0x001, carry=0, one retire pulse.
REQ-037 mem[0]=0xA010, mem[0x010]=0xFFFF, mem[1]=0x2011, mem[0x011]=0x0001 -> after 10 cycles ac=0x0000, carry=1, pc=0x002.
REQ-038 LDA giving ac=0x1234, then 0x9020 with mem[0x020]=0x0050 -> exactly one cycle mem_we=1, mem_addr=0x050, mem_wdata=0x1234; ac=0 afterwards; STA took 6 cycles.
REQ-039 JPA 0x5030, mem[0x030]=0x0200: with ac=0 -> pc increments only (3 cycles); with ac=1 -> pc=0x200 after 5 cycles.
REQ-040 pc=0xFFF holding NOT (0x0000) -> pc=0x000, ac inverted; then 0xE000 -> halted=1, mem_we=0 for 20 cycles.
REQ-041 rst asserted during STORE -> no write that edge, all registers 0, fetch resumes at 0x000.

Source files
------------

// File: rtl/acc_cpu_p.sv
`default_nettype none
// ============================================================================
// Module   : acc_cpu_p
// Purpose  : Multi-cycle accumulator CPU with one memory port. Eight
//            opcodes (NOT, ADC, JPA, INC, STA, LDA, AND, HLT), each with an
//            optional single level of indirection through memory.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       clock; every state change is on the rising edge
//   rst        in   1       synchronous, active-high reset
//   mem_addr   out  ADDR_W  memory address (PC while fetching, MA otherwise)
//   mem_rdata  in   DATA_W  synchronous-read data, valid one cycle after
//                           mem_addr was presented
//   mem_wdata  out  DATA_W  store data (always the accumulator)
//   mem_we     out  1       write strobe, only in STORE and never under reset
//   ac         out  DATA_W  accumulator
//   carry      out  1       carry flag
//   pc         out  ADDR_W  program counter
//   halted     out  1       high while halted
//   retire     out  1       one-cycle pulse in the last cycle of an instruction
// ============================================================================
module acc_cpu_p #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter bit STA_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] ac,
  output logic              carry,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              retire
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_LOADIR = 4'd1,
    S_DECODE = 4'd2,
    S_IND0   = 4'd3,
    S_IND1   = 4'd4,
    S_OPER0  = 4'd5,
    S_OPER1  = 4'd6,
    S_STORE  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [2:0] c_op_not = 3'b000;
  localparam logic [2:0] c_op_adc = 3'b001;
  localparam logic [2:0] c_op_jpa = 3'b010;
  localparam logic [2:0] c_op_inc = 3'b011;
  localparam logic [2:0] c_op_sta = 3'b100;
  localparam logic [2:0] c_op_lda = 3'b101;
  localparam logic [2:0] c_op_and = 3'b110;
  localparam logic [2:0] c_op_hlt = 3'b111;

  localparam logic [ADDR_W-1:0] c_pc_step  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W:0]   c_inc_step = {{DATA_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_ma;
  logic [DATA_W-1:0]   r_ac;
  logic                r_carry;
  // Only the opcode and addressing-mode bits of IR are ever consulted; the
  // operand address is captured straight into MA during LOADIR.
  logic [3:0]          r_ir_hi;

  logic [2:0]          w_op;
  logic                w_am;
  logic                w_ac_nz;
  logic [ADDR_W-1:0]   w_ptr;
  logic [DATA_W:0]     w_adc_sum;
  logic [DATA_W:0]     w_inc_sum;

  assign w_op    = r_ir_hi[3:1];
  assign w_am    = r_ir_hi[0];
  assign w_ac_nz = (r_ac != '0);
  assign w_ptr   = mem_rdata[ADDR_W-1:0];

  assign w_adc_sum = {1'b0, r_ac} + {1'b0, mem_rdata} + {{DATA_W{1'b0}}, r_carry};
  assign w_inc_sum = {1'b0, r_ac} + c_inc_step;

  assign ac        = r_ac;
  assign carry     = r_carry;
  assign pc        = r_pc;
  assign mem_wdata = r_ac;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = S_FETCH;
    mem_addr     = r_ma;
    mem_we       = 1'b0;
    halted       = 1'b0;
    retire       = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_addr     = r_pc;
        w_next_state = S_LOADIR;
      end

      S_LOADIR: begin
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        case (w_op)
          c_op_not, c_op_inc: w_next_state = S_FETCH;
          c_op_hlt:           w_next_state = S_HALT;
          // A jump on a zero accumulator is a no-op, so it never needs the
          // pointer read even when indirect.
          c_op_jpa:           w_next_state = (w_ac_nz && w_am) ? S_IND0 : S_FETCH;
          c_op_sta:           w_next_state = w_am ? S_IND0 : S_STORE;
          default:            w_next_state = w_am ? S_IND0 : S_OPER0;
        endcase
      end

      S_IND0: begin
        w_next_state = S_IND1;
      end

      S_IND1: begin
        case (w_op)
          c_op_jpa: w_next_state = S_FETCH;
          c_op_sta: w_next_state = S_STORE;
          default:  w_next_state = S_OPER0;
        endcase
      end

      S_OPER0: begin
        w_next_state = S_OPER1;
      end

      S_OPER1: begin
        w_next_state = S_FETCH;
      end

      S_STORE: begin
        mem_we       = ~rst;
        w_next_state = S_FETCH;
      end

      S_HALT: begin
        halted       = 1'b1;
        w_next_state = S_HALT;
      end

      default: begin
        w_next_state = S_FETCH;
      end
    endcase

    // HLT retires in DECODE even though it heads to HALT, not FETCH.
    retire = ~rst && ((w_next_state == S_FETCH) ||
                      ((r_state == S_DECODE) && (w_op == c_op_hlt)));
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_ma    <= '0;
      r_ac    <= '0;
      r_carry <= 1'b0;
      r_ir_hi <= '0;
    end else begin
      case (r_state)
        S_LOADIR: begin
          r_ir_hi <= mem_rdata[DATA_W-1:DATA_W-4];
          r_ma    <= mem_rdata[ADDR_W-1:0];
          r_pc    <= r_pc + c_pc_step;
        end

        S_DECODE: begin
          case (w_op)
            c_op_not: r_ac <= ~r_ac;
            c_op_inc: {r_carry, r_ac} <= w_inc_sum;
            c_op_jpa: begin
              if (w_ac_nz && !w_am) begin
                r_pc <= r_ma;
              end
            end
            default: begin
            end
          endcase
        end

        S_IND1: begin
          if (w_op == c_op_jpa) begin
            r_pc <= w_ptr;
          end else begin
            r_ma <= w_ptr;
          end
        end

        S_OPER1: begin
          case (w_op)
            c_op_adc: {r_carry, r_ac} <= w_adc_sum;
            c_op_lda: r_ac <= mem_rdata;
            c_op_and: r_ac <= r_ac & mem_rdata;
            default: begin
            end
          endcase
        end

        S_STORE: begin
          if (STA_CLEAR) begin
            r_ac <= '0;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_cpu_p
// Purpose  : Self-checking bench for acc_cpu_p (DATA_W=16, ADDR_W=12,
//            STA_CLEAR=1) with a synchronous-read RAM model. Expected
//            per-instruction results are queued before a program runs and
//            popped as each instruction retires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_cpu_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] ac;
  logic        carry;
  logic [11:0] pc;
  logic        halted;
  logic        retire;

  acc_cpu_p #(.DATA_W(16), .ADDR_W(12), .STA_CLEAR(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .ac        (ac),
    .carry     (carry),
    .pc        (pc),
    .halted    (halted),
    .retire    (retire)
  );

  always #5 clk = ~clk;

  // RAM model with a bench-side load port
  logic [15:0] mem [0:4095];
  logic        tb_we = 1'b0;
  logic [11:0] tb_waddr = '0;
  logic [15:0] tb_wdata = '0;

  logic [27:0] wr_q [$];
  int          retire_cnt = 0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (retire) retire_cnt++;
  end

  typedef struct {
    string       tag;
    int          lat;
    logic [15:0] ac;
    logic        c;
    logic [11:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  // Runs from a FETCH cycle until retire, then one more edge so the
  // instruction's register updates are visible. 999 means no retire seen.
  task automatic step_instr(output int lat);
    bit done = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      lat++;
      if (retire) done = 1'b1;
      tick();
    end
    if (!done) lat = 999;
  endtask

  task automatic push(input string t, input int l, input logic [15:0] a,
                      input logic c, input logic [11:0] p);
    exp_t e;
    e.tag = t; e.lat = l; e.ac = a; e.c = c; e.pc = p;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    hold_reset();
    total++;
    if ({ac, carry, pc, halted} !== 30'd0) $display("FAIL reset_regs: got ac=%h c=%b pc=%h h=%b, expected all 0", ac, carry, pc, halted);
    else passed++;
    total++;
    if ({mem_we, retire} !== 2'b00) $display("FAIL reset_strobes: got we=%b retire=%b, expected 0 0", mem_we, retire);
    else passed++;
    total++;
    if (mem_addr !== 12'h000) $display("FAIL reset_addr: got %h, expected 000", mem_addr);
    else passed++;
  endtask

  task automatic test_inc();
    int lat, r0;
    exp_t e;
    hold_reset();
    load(12'h000, 16'h6000);
    load(12'h001, 16'hE000);
    push("inc", 3, 16'h0001, 1'b0, 12'h001);
    r0 = retire_cnt;
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_instr(lat);
      total++;
      if (lat !== e.lat) $display("FAIL %s_latency: got %0d, expected %0d", e.tag, lat, e.lat);
      else passed++;
      total++;
      if ({ac, carry, pc} !== {e.ac, e.c, e.pc}) $display("FAIL %s_state: got ac=%h c=%b pc=%h, expected ac=%h c=%b pc=%h", e.tag, ac, carry, pc, e.ac, e.c, e.pc);
      else passed++;
    end
    total++;
    if (retire_cnt - r0 !== 1) $display("FAIL inc_retire_pulses: got %0d, expected 1", retire_cnt - r0);
    else passed++;
  endtask

  task automatic test_adc();
    int lat;
    exp_t e;
    hold_reset();
    load(12'h000, 16'hA010);  // LDA 0x010
    load(12'h001, 16'h2011);  // ADC 0x011
    load(12'h002, 16'h2012);  // ADC 0x012 with carry in
    load(12'h003, 16'h6000);  // INC
    load(12'h004, 16'hE000);  // HLT
    load(12'h010, 16'hFFFF);
    load(12'h011, 16'h0001);
    load(12'h012, 16'h0005);
    push("lda", 5, 16'hFFFF, 1'b0, 12'h001);
    push("adc_ovf", 5, 16'h0000, 1'b1, 12'h002);
    push("adc_cin", 5, 16'h0006, 1'b0, 12'h003);
    push("inc2", 3, 16'h0007, 1'b0, 12'h004);
    push("hlt", 3, 16'h0007, 1'b0, 12'h005);
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_instr(lat);
      total++;
      if (lat !== e.lat) $display("FAIL %s_latency: got %0d, expected %0d", e.tag, lat, e.lat);
      else passed++;
      total++;
      if ({ac, carry, pc} !== {e.ac, e.c, e.pc}) $display("FAIL %s_state: got ac=%h c=%b pc=%h, expected ac=%h c=%b pc=%h", e.tag, ac, carry, pc, e.ac, e.c, e.pc);
      else passed++;
    end
    total++;
    if (halted !== 1'b1) $display("FAIL adc_halted: got %b, expected 1", halted);
    else passed++;
  endtask

  task automatic test_sta();
    int lat;
    exp_t e;
    hold_reset();
    load(12'h000, 16'hA010);  // LDA 0x010
    load(12'h001, 16'h9020);  // STA @0x020 -> 0x050
    load(12'h002, 16'hA050);  // LDA 0x050 (reads back the stored word)
    load(12'h003, 16'h8060);  // STA 0x060 direct
    load(12'h004, 16'hE000);
    load(12'h010, 16'h1234);
    load(12'h020, 16'h0050);
    load(12'h050, 16'h0000);
    push("sta_lda", 5, 16'h1234, 1'b0, 12'h001);
    push("sta_ind", 6, 16'h0000, 1'b0, 12'h002);
    push("sta_rdbk", 5, 16'h1234, 1'b0, 12'h003);
    push("sta_dir", 4, 16'h0000, 1'b0, 12'h004);
    wr_q.delete();
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_instr(lat);
      total++;
      if (lat !== e.lat) $display("FAIL %s_latency: got %0d, expected %0d", e.tag, lat, e.lat);
      else passed++;
      total++;
      if ({ac, carry, pc} !== {e.ac, e.c, e.pc}) $display("FAIL %s_state: got ac=%h c=%b pc=%h, expected ac=%h c=%b pc=%h", e.tag, ac, carry, pc, e.ac, e.c, e.pc);
      else passed++;
    end
    total++;
    if (wr_q.size() !== 2) $display("FAIL sta_write_count: got %0d, expected 2", wr_q.size());
    else passed++;
    if (wr_q.size() == 2) begin
      total++;
      if (wr_q[0] !== {12'h050, 16'h1234}) $display("FAIL sta_write0: got %h, expected %h", wr_q[0], {12'h050, 16'h1234});
      else passed++;
      total++;
      if (wr_q[1] !== {12'h060, 16'h1234}) $display("FAIL sta_write1: got %h, expected %h", wr_q[1], {12'h060, 16'h1234});
      else passed++;
    end
  endtask

  task automatic test_jpa();
    int lat;
    exp_t e;
    hold_reset();
    load(12'h000, 16'h5030);  // JPA @0x030 with ac=0: not taken
    load(12'h001, 16'h6000);  // INC
    load(12'h002, 16'h5030);  // JPA @0x030 taken -> 0x200
    load(12'h030, 16'h0200);
    load(12'h200, 16'h4300);  // JPA 0x300 direct
    load(12'h300, 16'hE000);
    push("jpa_nt", 3, 16'h0000, 1'b0, 12'h001);
    push("jpa_inc", 3, 16'h0001, 1'b0, 12'h002);
    push("jpa_ind", 5, 16'h0001, 1'b0, 12'h200);
    push("jpa_dir", 3, 16'h0001, 1'b0, 12'h300);
    push("jpa_hlt", 3, 16'h0001, 1'b0, 12'h301);
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_instr(lat);
      total++;
      if (lat !== e.lat) $display("FAIL %s_latency: got %0d, expected %0d", e.tag, lat, e.lat);
      else passed++;
      total++;
      if ({ac, carry, pc} !== {e.ac, e.c, e.pc}) $display("FAIL %s_state: got ac=%h c=%b pc=%h, expected ac=%h c=%b pc=%h", e.tag, ac, carry, pc, e.ac, e.c, e.pc);
      else passed++;
    end
  endtask

  // PC wrap, then HLT at 0 (planted there by the program itself), then
  // 20 idle halted cycles, then reset out of HALT.
  task automatic test_wrap_halt();
    int lat, bad;
    exp_t e;
    hold_reset();
    load(12'h000, 16'hA010);  // LDA 0x010 (=HLT word)
    load(12'h001, 16'h8000);  // STA 0x000
    load(12'h002, 16'hA011);  // LDA 0x011 (=1)
    load(12'h003, 16'h4FFF);  // JPA 0xFFF
    load(12'hFFF, 16'h0000);  // NOT
    load(12'h010, 16'hE000);
    load(12'h011, 16'h0001);
    push("w_lda", 5, 16'hE000, 1'b0, 12'h001);
    push("w_sta", 4, 16'h0000, 1'b0, 12'h002);
    push("w_lda1", 5, 16'h0001, 1'b0, 12'h003);
    push("w_jpa", 3, 16'h0001, 1'b0, 12'hFFF);
    push("w_not", 3, 16'hFFFE, 1'b0, 12'h000);
    push("w_hlt", 3, 16'hFFFE, 1'b0, 12'h001);
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_instr(lat);
      total++;
      if (lat !== e.lat) $display("FAIL %s_latency: got %0d, expected %0d", e.tag, lat, e.lat);
      else passed++;
      total++;
      if ({ac, carry, pc} !== {e.ac, e.c, e.pc}) $display("FAIL %s_state: got ac=%h c=%b pc=%h, expected ac=%h c=%b pc=%h", e.tag, ac, carry, pc, e.ac, e.c, e.pc);
      else passed++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted !== 1'b1 || mem_we !== 1'b0 || retire !== 1'b0 ||
          ac !== 16'hFFFE || pc !== 12'h001) bad++;
      tick();
    end
    total++;
    if (bad !== 0) $display("FAIL halt_idle: got %0d bad cycles, expected 0", bad);
    else passed++;
    // Reset out of HALT: fetch resumes at 0, which now holds HLT.
    hold_reset();
    total++;
    if (halted !== 1'b0) $display("FAIL halt_reset: got halted=%b, expected 0", halted);
    else passed++;
    rst = 1'b0;
    step_instr(lat);
    total++;
    if ({lat, pc, halted} !== {32'd3, 12'h001, 1'b1}) $display("FAIL halt_resume: got lat=%0d pc=%h h=%b, expected lat=3 pc=001 h=1", lat, pc, halted);
    else passed++;
  endtask

  task automatic test_reset_mid_store();
    int lat;
    hold_reset();
    load(12'h000, 16'hA010);
    load(12'h001, 16'h9020);
    load(12'h010, 16'h5555);
    load(12'h020, 16'h0070);
    load(12'h070, 16'h0000);
    wr_q.delete();
    rst = 1'b0;
    step_instr(lat);
    total++;
    if ({lat, ac} !== {32'd5, 16'h5555}) $display("FAIL mid_lda: got lat=%0d ac=%h, expected lat=5 ac=5555", lat, ac);
    else passed++;
    repeat (5) tick();  // FETCH, LOADIR, DECODE, IND0, IND1 -> STORE
    total++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h070, 16'h5555}) $display("FAIL mid_store_seen: got we=%b a=%h d=%h, expected we=1 a=070 d=5555", mem_we, mem_addr, mem_wdata);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({mem_we, retire} !== 2'b00) $display("FAIL mid_store_gate: got we=%b retire=%b, expected 0 0", mem_we, retire);
    else passed++;
    tick();
    total++;
    if ({ac, carry, pc, halted, mem_addr} !== 42'd0) $display("FAIL mid_store_regs: got ac=%h c=%b pc=%h h=%b a=%h, expected all 0", ac, carry, pc, halted, mem_addr);
    else passed++;
    total++;
    if (wr_q.size() !== 0 || mem[12'h070] !== 16'h0000) $display("FAIL mid_store_nowrite: got %0d writes mem=%h, expected 0 writes mem=0000", wr_q.size(), mem[12'h070]);
    else passed++;
    rst = 1'b0;
    step_instr(lat);
    total++;
    if ({lat, ac, pc} !== {32'd5, 16'h5555, 12'h001}) $display("FAIL mid_resume: got lat=%0d ac=%h pc=%h, expected lat=5 ac=5555 pc=001", lat, ac, pc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_inc();
    test_adc();
    test_sta();
    test_jpa();
    test_wrap_halt();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
